// File: rtl/seg_display_arbiter_if.sv
// seg_display_arbiter_if
//   Bundles the requester side and the display register bus of the
//   seven-segment display arbiter.
//   master : arbiter side (reads requests, drives grants and display bus)
//   slave  : requester/display side (drives requests, observes the rest)
//   req        NREQ      level request per requester, held until gnt
//   req_value  NREQ*16   {PairA,PairB} per requester, requester i at [16*i+15:16*i]
//   req_ctrl   NREQ*8    Control byte per requester, requester i at [8*i+7:8*i]
//   gnt        NREQ      one-cycle completion pulse
//   busy       1         arbiter is not idle
//   owner      IDXW      last granted requester
//   disp_*               display register bus (addr, data, wr, cen, rd)
interface seg_display_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*16-1:0] req_value;
  logic [NREQ*8-1:0]  req_ctrl;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic [IDXW-1:0]    owner;
  logic [1:0]         disp_addr;
  logic [7:0]         disp_data;
  logic               disp_wr;
  logic               disp_cen;
  logic               disp_rd;

  modport master (
    input  req, req_value, req_ctrl,
    output gnt, busy, owner, disp_addr, disp_data, disp_wr, disp_cen, disp_rd
  );

  modport slave (
    output req, req_value, req_ctrl,
    input  gnt, busy, owner, disp_addr, disp_data, disp_wr, disp_cen, disp_rd
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//   Round-robin sharing of the four-digit seven-segment display between
//   NREQ requesters. Sole master of the display register bus: writes the
//   Divisor once after reset, then for each granted request writes Control,
//   SegmentPairA and SegmentPairB and pulses gnt for that requester.
//   An optional hold window keeps the current owner on the display.
//   clk : system clock, all state on posedge
//   rst : asynchronous, active-low reset
//   bus : seg_display_arbiter_if.master (requests, grants, display bus)
module seg_display_arbiter #(
  parameter int          NREQ         = 4,
  parameter int          IDXW         = 2,
  parameter logic [7:0]  DIVISOR_INIT = 8'h20,
  parameter logic [15:0] HOLD_CYCLES  = 16'd0
) (
  input logic                   clk,
  input logic                   rst,
  seg_display_arbiter_if.master bus
);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_CTRL = 3'd2;
  localparam logic [2:0] S_PA   = 3'd3;
  localparam logic [2:0] S_PB   = 3'd4;
  localparam logic [2:0] S_ACK  = 3'd5;

  localparam logic [IDXW:0]   NREQ_W   = (IDXW+1)'(NREQ);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ-1);
  localparam logic [NREQ-1:0] ONE      = NREQ'(1);

  logic [2:0]      state;
  logic [IDXW-1:0] rr_ptr;
  logic [15:0]     hold_cnt;
  logic [7:0]      ctrl_q;
  logic [15:0]     value_q;

  logic [NREQ-1:0] gnt_q;
  logic            busy_q;
  logic [IDXW-1:0] owner_q;
  logic [1:0]      addr_q;
  logic [7:0]      data_q;
  logic            wr_q;

  // Round-robin scan from rr_ptr upward with wrap; during a hold window
  // only the current owner is eligible.
  logic [NREQ-1:0] elig;
  logic            found;
  logic [IDXW-1:0] win;
  logic [IDXW:0]   slot;
  logic [7:0]      sel_ctrl;
  logic [15:0]     sel_value;

  always_comb begin
    elig  = (hold_cnt != '0) ? (bus.req & (ONE << owner_q)) : bus.req;
    found = 1'b0;
    win   = '0;
    slot  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      slot = {1'b0, rr_ptr} + (IDXW+1)'(k);
      if (slot >= NREQ_W) slot = slot - NREQ_W;
      if (!found && elig[slot[IDXW-1:0]]) begin
        found = 1'b1;
        win   = slot[IDXW-1:0];
      end
    end
  end

  always_comb begin
    sel_ctrl  = '0;
    sel_value = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDXW'(i) == win) begin
        sel_ctrl  = bus.req_ctrl[i*8 +: 8];
        sel_value = bus.req_value[i*16 +: 16];
      end
    end
  end

  // Outputs are registered from the current state, so the bus shows each
  // state's write one cycle after the state is entered: arbitration at edge N
  // puts Control on the bus after N+1 and gnt after N+4, while the state
  // register is already back in IDLE and arbitrates again at N+5.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_INIT;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      ctrl_q   <= '0;
      value_q  <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      owner_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
    end else begin
      gnt_q  <= '0;
      wr_q   <= 1'b0;
      busy_q <= (state != S_IDLE);
      case (state)
        S_INIT: begin
          addr_q <= 2'b01;
          data_q <= DIVISOR_INIT;
          wr_q   <= 1'b1;
          state  <= S_IDLE;
        end
        S_IDLE: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 16'd1;
          if (found) begin
            ctrl_q  <= sel_ctrl;
            value_q <= sel_value;
            owner_q <= win;
            rr_ptr  <= (win == LAST_IDX) ? '0 : win + IDXW'(1);
            state   <= S_CTRL;
          end
        end
        S_CTRL: begin
          addr_q <= 2'b00;
          data_q <= ctrl_q;
          wr_q   <= 1'b1;
          state  <= S_PA;
        end
        S_PA: begin
          addr_q <= 2'b10;
          data_q <= value_q[15:8];
          wr_q   <= 1'b1;
          state  <= S_PB;
        end
        S_PB: begin
          addr_q <= 2'b11;
          data_q <= value_q[7:0];
          wr_q   <= 1'b1;
          state  <= S_ACK;
        end
        S_ACK: begin
          gnt_q    <= ONE << owner_q;
          hold_cnt <= HOLD_CYCLES;
          state    <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;
  assign bus.disp_addr = addr_q;
  assign bus.disp_data = data_q;
  assign bus.disp_wr   = wr_q;
  assign bus.disp_cen  = wr_q;
  assign bus.disp_rd   = 1'b0;

endmodule
